// File: rtl/slider_move_ctrl_pkg.sv
// slider_move_ctrl_pkg: direction bit indices, owner encodings and default pacing for the slider motion controller.
package slider_move_ctrl_pkg;
    localparam int DIR_GO   = 0;
    localparam int DIR_BACK = 1;
    localparam int DIR_DOWN = 2;
    localparam int DIR_UP   = 3;
    localparam int STEP_FRAMES_DEF = 2;
    localparam int IDLE_FRAMES_DEF = 600;
    typedef enum logic {OWN_PLAYER = 1'b0, OWN_DEMO = 1'b1} owner_e;
endpackage

// File: rtl/slider_axis_step.sv
// slider_axis_step: one motion axis; cancels opposing requests and emits step pulses on a press edge or divider wrap.
module slider_axis_step (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       wrap,
    input  logic       clr,
    output logic       pos,
    output logic       neg,
    output logic       press
);
    logic resolved, active_d, active_q, pos_d, pos_q, neg_d, neg_q;
    always_comb begin
        resolved = req[0] ^ req[1];
        press    = resolved && !active_q;
        active_d = !clr && resolved;
        pos_d    = !clr && resolved && req[0] && (press || wrap);
        neg_d    = !clr && resolved && req[1] && (press || wrap);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            pos_q    <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            pos_q    <= pos_d;
            neg_q    <= neg_d;
        end
    end
    assign pos = pos_q;
    assign neg = neg_q;
endmodule

// File: rtl/slider_move_ctrl.sv
// slider_move_ctrl: arbitrates player/demo ownership of the slider and paces requests into one-cycle step pulses.
module slider_move_ctrl
    import slider_move_ctrl_pkg::*;
#(
    parameter int STEP_FRAMES = STEP_FRAMES_DEF,
    parameter int IDLE_FRAMES = IDLE_FRAMES_DEF,
    parameter int IDLE_W      = 10
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       iFrame_tick,
    input  logic [3:0] iKey_dir,
    input  logic [3:0] iDemo_dir,
    input  logic       iDemo_en,
    output logic       oSlider_go,
    output logic       oSlider_back,
    output logic       oSlider_up,
    output logic       oSlider_down,
    output logic       oOwner
);
    localparam int DIV_W = STEP_FRAMES > 1 ? $clog2(STEP_FRAMES) : 1;
    owner_e owner_d, owner_q;
    logic [IDLE_W-1:0] idle_d, idle_q;
    logic [DIV_W-1:0] div_d, div_q;
    logic [3:0] dir;
    logic leave, enter, switch_own, wrap, press_h, press_v;
    always_comb begin
        dir        = (owner_q == OWN_DEMO) ? iDemo_dir : iKey_dir;
        leave      = (owner_q == OWN_DEMO) && (|iKey_dir || !iDemo_en);
        enter      = (owner_q == OWN_PLAYER) && (idle_q == IDLE_W'(IDLE_FRAMES)) && iDemo_en;
        switch_own = leave || enter;
        owner_d    = leave ? OWN_PLAYER : enter ? OWN_DEMO : owner_q;
        idle_d     = (|iKey_dir || leave) ? '0 :
                     (iFrame_tick && idle_q != IDLE_W'(IDLE_FRAMES)) ? idle_q + 1'b1 : idle_q;
        wrap       = iFrame_tick && (div_q == DIV_W'(STEP_FRAMES - 1));
        // a fresh press restarts pacing so the next held step is a full period away
        div_d      = (switch_own || press_h || press_v) ? '0 :
                     iFrame_tick ? (wrap ? '0 : div_q + 1'b1) : div_q;
    end
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            owner_q <= OWN_PLAYER;
            idle_q  <= '0;
            div_q   <= '0;
        end else begin
            owner_q <= owner_d;
            idle_q  <= idle_d;
            div_q   <= div_d;
        end
    end
    slider_axis_step u_horiz (
        .clk   (iVGA_CLK),
        .rst_n (iRST_n),
        .req   ({dir[DIR_BACK], dir[DIR_GO]}),
        .wrap  (wrap),
        .clr   (switch_own),
        .pos   (oSlider_go),
        .neg   (oSlider_back),
        .press (press_h)
    );
    slider_axis_step u_vert (
        .clk   (iVGA_CLK),
        .rst_n (iRST_n),
        .req   ({dir[DIR_DOWN], dir[DIR_UP]}),
        .wrap  (wrap),
        .clr   (switch_own),
        .pos   (oSlider_up),
        .neg   (oSlider_down),
        .press (press_v)
    );
    assign oOwner = owner_q;
endmodule
